// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin scheduler sharing one FP add/sub unit among
// NUM_REQ requesters. One operation is in flight at a time: accept, start the
// unit, wait for done (or the watchdog), then hold the response until the
// granted requester takes it.
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. req_ready is a combinational one-hot that is non-zero only in
// IDLE. rsp_valid is registered and held, with its data, until
// rsp_ready[grant] is high on an edge. rsp_ready on other indices is ignored.
module fp_add_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock_100kHz,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_op_a,
  input  logic [NUM_REQ*32-1:0]  req_op_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [3:0]             rsp_status,
  output logic                   rsp_timeout,
  output logic [31:0]            fpu_op_a,
  output logic [31:0]            fpu_op_b,
  output logic                   fpu_start,
  input  logic                   fpu_done,
  input  logic [31:0]            fpu_data,
  input  logic [3:0]             fpu_status,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW:0]   NUM_REQ_W = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       grant;
  logic [WW-1:0]       wdog;
  logic [PW-1:0]       winner;
  logic                found;
  logic [PW:0]         cand;
  logic [31:0]         win_a;
  logic [31:0]         win_b;
  logic [NUM_REQ-1:0]  grant_1h;

  // Round-robin pick: first valid requester scanning upward from ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_valid[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PW'(i)) begin
        win_a = req_op_a[32*i +: 32];
        win_b = req_op_b[32*i +: 32];
      end
    end
  end

  // Accept strobe: one-hot winner, only while idle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found) req_ready[winner] = 1'b1;
  end

  // One-hot of the latched grant, used to steer rsp_valid.
  always_comb begin
    grant_1h = '0;
    grant_1h[grant] = 1'b1;
  end

  // Main sequencer: accept, start pulse, wait/watchdog, hold response.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant       <= '0;
      wdog        <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      fpu_start   <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= winner;
            fpu_op_a  <= win_a;
            fpu_op_b  <= win_b;
            ptr       <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            // Start is raised here so it is high for exactly the ISSUE cycle.
            fpu_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A done pulse seen here belongs to no operation of ours; ignore it.
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_done) begin
            rsp_data    <= fpu_data;
            rsp_status  <= fpu_status;
            rsp_timeout <= 1'b0;
            rsp_valid   <= grant_1h;
            state       <= S_RESPOND;
          end else if (wdog == WD_LAST) begin
            rsp_data    <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= grant_1h;
            state       <= S_RESPOND;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESPOND: begin
          if (rsp_ready[grant]) begin
            rsp_valid <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: randomized requesters and FPU stub, a
// transaction-level model checked every cycle, plus directed scenarios with
// hand-computed expectations.
module tb_fp_add_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clock_100kHz = 1'b0;
  logic reset = 1'b1;
  always #5 clock_100kHz = ~clock_100kHz;

  int cyc = 0;
  always @(posedge clock_100kHz) cyc <= cyc + 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_op_a;
  logic [NUM_REQ*32-1:0] req_op_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_status;
  logic                  rsp_timeout;
  logic [31:0]           fpu_op_a;
  logic [31:0]           fpu_op_b;
  logic                  fpu_start;
  logic                  fpu_done;
  logic [31:0]           fpu_data;
  logic [3:0]            fpu_status;
  logic                  busy;
  logic [1:0]            dbg_state;

  fp_add_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clock_100kHz(clock_100kHz),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op_a(req_op_a),
    .req_op_b(req_op_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .rsp_timeout(rsp_timeout),
    .fpu_op_a(fpu_op_a),
    .fpu_op_b(fpu_op_b),
    .fpu_start(fpu_start),
    .fpu_done(fpu_done),
    .fpu_data(fpu_data),
    .fpu_status(fpu_status),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          g;
    logic [31:0] d;
    logic [3:0]  s;
    logic        to;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
  } rsp_rec_t;

  rsp_rec_t rsp_log[$];
  int       grant_log[$];
  int       start_cnt = 0;

  // ---------------- stimulus controls (written by main only) ----------------
  int          target[NUM_REQ];
  int          src_prob = 100;
  bit          fix_en = 0;
  logic [31:0] fix_a = '0, fix_b = '0;
  int          rsp_mode = 0;          // 0 all ready, 1 random, 2 none
  int          stub_mode = 0;         // 0 answer after delay, 1 never answer
  int          stub_delay = 3;
  bit          stub_rand_delay = 0;
  bit          stub_rand_data = 1;
  bit          stub_issue_pulse = 0;
  logic [31:0] stub_data = '0;
  logic [3:0]  stub_status = '0;
  int          force_done_cyc = -1;

  // ---------------- model state (written by compare only) ----------------
  logic [NUM_REQ-1:0] acc_mask = '0;
  bit                 t_act = 0;
  int                 t_e = 0, t_r = 0, t_g = 0;
  logic [31:0]        e_data = '0;
  logic [3:0]         e_stat = '0;
  logic               e_to = 1'b0;
  int                 m_ptr = 0;
  logic [31:0]        m_a = '0, m_b = '0;

  // Round-robin rule: first valid index at or after p, wrapping.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- driver: requesters, response sink, FPU stub ----------------
  int issued[NUM_REQ];
  initial begin
    bit pending;
    int cnt;
    pending = 0;
    cnt = 0;
    req_valid = '0;
    req_op_a = '0;
    req_op_b = '0;
    rsp_ready = '0;
    fpu_done = 1'b0;
    fpu_data = '0;
    fpu_status = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      issued[i] = 0;
      target[i] = 0;
    end
    forever begin
      @(posedge clock_100kHz);
      #1;
      fpu_done = 1'b0;
      fpu_data = $urandom;
      fpu_status = 4'($urandom);
      if (reset) begin
        pending = 0;
      end else if (fpu_start) begin
        pending = (stub_mode == 0);
        cnt = stub_rand_delay ? $urandom_range(1, TIMEOUT + 2) : stub_delay;
        if (stub_issue_pulse) begin
          fpu_done = 1'b1;
          fpu_data = 32'h1111_1111;
        end
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending = 0;
          fpu_done = 1'b1;
          if (!stub_rand_data) begin
            fpu_data = stub_data;
            fpu_status = stub_status;
          end
        end
      end
      if (cyc == force_done_cyc) begin
        fpu_done = 1'b1;
        fpu_data = 32'hBAD0_0001;
        fpu_status = 4'hF;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && issued[i] < target[i] && $urandom_range(0, 99) < src_prob) begin
          req_valid[i] = 1'b1;
          issued[i]++;
          req_op_a[32*i +: 32] = (fix_en && i == 0) ? fix_a : $urandom;
          req_op_b[32*i +: 32] = (fix_en && i == 0) ? fix_b : $urandom;
        end
      end
      case (rsp_mode)
        0: rsp_ready = '1;
        1: rsp_ready = NUM_REQ'($urandom);
        default: rsp_ready = '0;
      endcase
    end
  end

  // ---------------- compare: model checked every cycle ----------------
  initial begin
    int w;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] exp_rv;
    rsp_rec_t rec;
    forever begin
      @(negedge clock_100kHz);
      if (cyc == 0) continue;
      if (fpu_start === 1'b1) start_cnt++;
      if (reset) begin
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst fpu_start", fpu_start, 0);
        chk("rst fpu_op_a", fpu_op_a, 0);
        chk("rst fpu_op_b", fpu_op_b, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst rsp_status", rsp_status, 0);
        chk("rst rsp_timeout", rsp_timeout, 0);
        acc_mask = '0;
        t_act = 0;
        m_ptr = 0;
        m_a = '0;
        m_b = '0;
      end else if (!t_act) begin
        w = pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("idle req_ready", req_ready, exp_rdy);
        chk("idle busy", busy, 0);
        chk("idle rsp_valid", rsp_valid, 0);
        chk("idle fpu_start", fpu_start, 0);
        chk("idle fpu_op_a", fpu_op_a, m_a);
        chk("idle fpu_op_b", fpu_op_b, m_b);
        acc_mask = req_valid & req_ready;
        if (w >= 0) begin
          t_act = 1;
          t_e = cyc + 1;
          t_r = 0;
          t_g = w;
          m_a = req_op_a[32*w +: 32];
          m_b = req_op_b[32*w +: 32];
          m_ptr = (w + 1) % NUM_REQ;
          grant_log.push_back(w);
        end
      end else begin
        acc_mask = '0;
        chk("busy", busy, 1);
        chk("busy req_ready", req_ready, 0);
        chk("fpu_op_a", fpu_op_a, m_a);
        chk("fpu_op_b", fpu_op_b, m_b);
        if (t_r == 0 || cyc < t_r) begin
          chk("fpu_start", fpu_start, 32'(cyc == t_e));
          chk("rsp_valid early", rsp_valid, 0);
          if (t_r == 0 && cyc > t_e) begin
            if (fpu_done === 1'b1) begin
              t_r = cyc + 1;
              e_data = fpu_data;
              e_stat = fpu_status;
              e_to = 1'b0;
            end else if (cyc == t_e + TIMEOUT) begin
              t_r = cyc + 1;
              e_data = '0;
              e_stat = '0;
              e_to = 1'b1;
            end
          end
        end else begin
          exp_rv = '0;
          exp_rv[t_g] = 1'b1;
          chk("rsp_valid", rsp_valid, exp_rv);
          chk("rsp_data", rsp_data, e_data);
          chk("rsp_status", rsp_status, e_stat);
          chk("rsp_timeout", rsp_timeout, e_to);
          chk("resp fpu_start", fpu_start, 0);
          if (cyc == t_r) begin
            rec.g = t_g;
            rec.d = rsp_data;
            rec.s = rsp_status;
            rec.to = rsp_timeout;
            rec.lat = t_r - t_e;
            rec.a = fpu_op_a;
            rec.b = fpu_op_b;
            rsp_log.push_back(rec);
          end
          if (rsp_ready[t_g]) t_act = 0;
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  function automatic bit drained();
    for (int i = 0; i < NUM_REQ; i++)
      if (issued[i] < target[i]) return 0;
    return (req_valid == '0) && !t_act;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clock_100kHz);
    while (k < budget && !drained()) begin
      @(negedge clock_100kHz);
      k++;
    end
    chk({name, " drained"}, 32'(k < budget), 1);
  endtask

  task automatic do_reset();
    @(posedge clock_100kHz);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock_100kHz);
    #2 reset = 1'b0;
  endtask

  task automatic chk_rsp(input string name, input int idx, input int g, input logic [31:0] d,
                         input logic [3:0] s, input logic to, input int lat);
    chk({name, " logged"}, 32'(rsp_log.size() > idx), 1);
    if (rsp_log.size() > idx) begin
      chk({name, " grant"}, rsp_log[idx].g, g);
      chk({name, " data"}, rsp_log[idx].d, d);
      chk({name, " status"}, rsp_log[idx].s, s);
      chk({name, " timeout"}, rsp_log[idx].to, to);
      chk({name, " latency"}, rsp_log[idx].lat, lat);
    end
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int n0, g0, k, s0, rv_cnt;
    repeat (3) @(posedge clock_100kHz);
    #2 reset = 1'b0;

    // Single request with known operands; done 3 cycles after start.
    stub_mode = 0; stub_rand_delay = 0; stub_delay = 3;
    stub_rand_data = 0; stub_data = 32'h40E0_0000; stub_status = 4'b0001;
    fix_en = 1; fix_a = 32'h4080_0000; fix_b = 32'h4040_0000;
    rsp_mode = 0; src_prob = 100;
    n0 = rsp_log.size();
    target[0] += 1;
    wait_drain("t1", 100);
    // start at accept+1, done 3 later, response 1 after done: 4 cycles after start edge
    chk_rsp("t1", n0, 0, 32'h40E0_0000, 4'b0001, 1'b0, 4);
    if (rsp_log.size() > n0) begin
      chk("t1 op_a", rsp_log[n0].a, 32'h4080_0000);
      chk("t1 op_b", rsp_log[n0].b, 32'h4040_0000);
    end
    fix_en = 0;

    // Both requesters continuously valid: grants alternate from 0.
    do_reset();
    stub_rand_data = 1; stub_delay = 2;
    g0 = grant_log.size();
    target[0] += 4; target[1] += 4;
    wait_drain("t2", 300);
    chk("t2 grant count", grant_log.size() - g0, 8);
    for (int j = 0; j < 8; j++)
      if (grant_log.size() > g0 + j) chk("t2 grant order", grant_log[g0 + j], j % 2);

    // Stub never answers: watchdog response TIMEOUT cycles into WAIT.
    stub_mode = 1;
    n0 = rsp_log.size();
    target[1] += 1;
    wait_drain("t3", 200);
    chk_rsp("t3", n0, 1, 32'h0, 4'h0, 1'b1, TIMEOUT + 1);

    // Response held off for 5 cycles: outputs stable, no new accept/start.
    stub_mode = 0; stub_rand_data = 0; stub_data = 32'hDEAD_BEEF; stub_status = 4'b1000;
    stub_delay = 2; rsp_mode = 2;
    target[0] += 1;
    k = 0;
    @(negedge clock_100kHz);
    while (k < 60 && rsp_valid == '0) begin
      @(negedge clock_100kHz);
      k++;
    end
    chk("t4 rsp seen", 32'(rsp_valid != '0), 1);
    target[1] += 1;
    s0 = start_cnt;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock_100kHz);
      chk("t4 hold rsp_valid", rsp_valid, 2'b01);
      chk("t4 hold rsp_data", rsp_data, 32'hDEAD_BEEF);
      chk("t4 hold rsp_status", rsp_status, 4'b1000);
      chk("t4 hold req_ready", req_ready, 0);
    end
    chk("t4 no start while held", start_cnt - s0, 0);
    rsp_mode = 0;
    wait_drain("t4", 200);

    // Reset in WAIT, then a stray done: nothing returned, pointer back to 0.
    stub_mode = 1;
    target[0] += 1;
    s0 = start_cnt;
    k = 0;
    while (k < 60 && start_cnt == s0) begin
      @(negedge clock_100kHz);
      k++;
    end
    chk("t5 start seen", 32'(start_cnt != s0), 1);
    repeat (3) @(posedge clock_100kHz);
    #2 reset = 1'b1;
    @(negedge clock_100kHz);
    chk("t5 busy in reset", busy, 0);
    chk("t5 rsp_valid in reset", rsp_valid, 0);
    @(posedge clock_100kHz);
    #2 reset = 1'b0;
    force_done_cyc = cyc + 1;
    rv_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock_100kHz);
      if (rsp_valid != '0 || busy) rv_cnt++;
    end
    chk("t5 no response after reset", rv_cnt, 0);
    stub_mode = 0; stub_delay = 1; stub_rand_data = 1;
    g0 = grant_log.size();
    target[0] += 1; target[1] += 1;
    wait_drain("t5", 200);
    if (grant_log.size() > g0 + 1) begin
      chk("t5 first grant", grant_log[g0], 0);
      chk("t5 second grant", grant_log[g0 + 1], 1);
    end

    // Done pulse during ISSUE is ignored; the WAIT pulse is returned.
    stub_issue_pulse = 1; stub_rand_data = 0;
    stub_data = 32'h4444_4444; stub_status = 4'b0101; stub_delay = 3;
    n0 = rsp_log.size();
    target[1] += 1;
    wait_drain("t6", 100);
    chk_rsp("t6", n0, 1, 32'h4444_4444, 4'b0101, 1'b0, 4);
    stub_issue_pulse = 0;

    // Done on the last watchdog cycle wins; one cycle later times out.
    stub_data = 32'h5555_5555; stub_status = 4'b0010; stub_delay = TIMEOUT;
    n0 = rsp_log.size();
    target[0] += 1;
    wait_drain("t7a", 100);
    chk_rsp("t7a", n0, 0, 32'h5555_5555, 4'b0010, 1'b0, TIMEOUT + 1);
    stub_delay = TIMEOUT + 1;
    n0 = rsp_log.size();
    target[1] += 1;
    wait_drain("t7b", 100);
    chk_rsp("t7b", n0, 1, 32'h0, 4'h0, 1'b1, TIMEOUT + 1);

    // Random soak: sparse requests, random latencies, random rsp_ready.
    stub_rand_delay = 1; stub_rand_data = 1; rsp_mode = 1; src_prob = 40;
    target[0] += 25; target[1] += 25;
    wait_drain("soak", 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
